clk_step_ctrl: RTL and testbench
================================

# clk_step_ctrl

Synchronous clock-mode controller for the processor core. It debounces the board pushbuttons and sequences the manual, auto-slow, auto-fast and burst run modes. It emits a single-cycle core clock-enable pulse, `oCPU_EN`, in the system clock domain. It replaces ripple-clocked key toggles and clock muxing: the core runs on `iCLK_50` qualified by `oCPU_EN`, so no derived clocks are needed.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: cycles a key level must stay stable before it is accepted (5 ms at 50 MHz).
- `DIV_W`, default 8: width of the divisor input.
- `SLOW_SHIFT`, default 18: the slow period is the divisor shifted left by this amount.
- `BURST_W`, default 16: width of the burst length.
- `iCLK_50`, input, 1: system clock, the only clock.
- `iRST_n`, input, 1: asynchronous, active-low reset.
- `iKEY`, input, 4: raw active-low pushbuttons.
  - [3] manual step.
  - [2] toggle auto/manual.
  - [1] toggle fast/slow.
  - [0] start burst.
- `iDiv`, input, `DIV_W`: clock divisor. 0 is treated as 1.
- `iBurstLen`, input, `BURST_W`: number of enables per burst. 0 means the burst is ignored.
- `iHalt`, input, 1: synchronous halt request from the core (break/trap).
- `oCPU_EN`, output, 1: core clock-enable, one cycle wide.
- `oMode`, output, 2: current mode.
  - 0 = MANUAL
  - 1 = AUTO_SLOW
  - 2 = AUTO_FAST
  - 3 = BURST
- `oBusy`, output, 1: high while a burst is active.
- `oStepCount`, output, 32: count of enables issued since reset.

## Operation
- **Key path (per key):**
  - 2-flop synchroniser, then a stability counter.
  - The debounced level updates after `DEBOUNCE_CYCLES` consecutive equal samples.
  - A press event is a one-cycle pulse on each 1→0 transition of the debounced level.
- **Period `P`:**
  - `D = max(iDiv, 1)`.
  - Fast and burst: `P = D`.
  - Slow: `P = D << SLOW_SHIFT`, using a `DIV_W + SLOW_SHIFT` bit counter.
- **Divider counter `cnt`:**
  - Increments every cycle in AUTO and BURST modes.
  - When `cnt >= P-1`: `oCPU_EN` = 1 next cycle and `cnt` returns to 0. Using `>=` makes a shrinking `iDiv` take effect without overrunning.
  - Cleared on every mode change.
- **Mode state machine:**
  - **Reset:** `oMode` = MANUAL, fast flag = 0.
  - **MANUAL:**
    - KEY3 event: one `oCPU_EN` pulse.
    - KEY2: go to AUTO_FAST if fast flag = 1, else AUTO_SLOW.
    - KEY0 with `iBurstLen` ≠ 0: go to BURST, load `remaining = iBurstLen`, `oBusy` = 1.
  - **AUTO_SLOW / AUTO_FAST:**
    - KEY2: go to MANUAL.
    - KEY1: toggle the fast flag and switch immediately between AUTO_SLOW and AUTO_FAST.
    - KEY3 and KEY0: ignored.
  - **MANUAL and fast flag:** KEY1 toggles the fast flag only.
  - **BURST:**
    - Enables at period `D`; `remaining` decrements on each enable.
    - The enable that takes `remaining` to 0 is the last one; the mode returns to MANUAL in the same cycle that pulse is issued.
    - KEY2 aborts the burst to MANUAL. Other keys are ignored.
- **`iHalt`:**
  - From any mode: MANUAL next cycle, burst aborted, `oBusy` = 0, no enable that cycle. The fast flag is kept.
  - Halt has priority over key events in the same cycle.
- **Simultaneous key events:** priority is KEY2 > KEY0 > KEY1 > KEY3.
- **`oStepCount`:** increments on each `oCPU_EN`; wraps from 2^32−1 to 0.
- **Reset mid-operation:** all state returns to its reset values immediately (asynchronous).

## Timing
- All outputs are registered.
- Reset values:
  - `oCPU_EN` = 0
  - `oMode` = 0
  - `oBusy` = 0
  - `oStepCount` = 0
  - Debounced key levels = 1 (released).
- Press-to-event latency: 2 sync cycles + `DEBOUNCE_CYCLES` + 1 cycles.
- Event-to-`oCPU_EN` (MANUAL): 1 cycle.
- Event-to-mode change: 1 cycle.
- AUTO: the first enable comes `P` cycles after mode entry, then one every `P` cycles.
- `oCPU_EN` is never high on two consecutive cycles unless `P` = 1.

## Configuration
- **`CLKCTRL_BURST_EN` defined:** BURST mode, `iBurstLen` handling, KEY0 and `oBusy` are implemented as above.
- **Not defined:**
  - The burst logic is omitted.
  - KEY0 is ignored.
  - `oBusy` is tied to 0.
  - `oMode` never takes the value 3.
  - The `iBurstLen` port remains but is unused.

## Structure
- Shared package `clk_ctrl_pkg`:
  - Mode encoding constants (MODE_MANUAL, MODE_AUTO_SLOW, MODE_AUTO_FAST, MODE_BURST).
  - Key index constants (KEY_STEP = 3, KEY_AUTO = 2, KEY_FAST = 1, KEY_BURST = 0).
- Sub-module `key_debounce`:
  - One instance per key, parameterised by `DEBOUNCE_CYCLES`.
  - Outputs the debounced level and the press pulse.
- The top level holds the mode FSM, the divider counter, the burst counter and the step counter.

## Test plan
Bench overrides: `DEBOUNCE_CYCLES` = 4, `SLOW_SHIFT` = 2.

1. **Reset:** hold `iRST_n` = 0 for 3 cycles, then release → `oMode` = 0, `oCPU_EN` = 0, `oStepCount` = 0.
2. **Bounce rejection:** in MANUAL, bounce KEY3 low for 2 cycles, then hold it low for 10 cycles → no pulse for the bounce, exactly one `oCPU_EN` pulse, `oStepCount` = 1.
3. **Auto modes:** set `iDiv` = 3, press KEY2 → AUTO_SLOW, enables every 12 cycles. Then press KEY1 → AUTO_FAST, enables every 3 cycles. Set `iDiv` = 0 → enables every cycle.
4. **Burst:** with `CLKCTRL_BURST_EN` defined, `iBurstLen` = 5, `iDiv` = 2, press KEY0 → exactly 5 enables 2 cycles apart, `oBusy` falls with the last one, `oMode` = 0.
5. **Halt:** in AUTO_FAST, assert `iHalt` for one cycle at the same time as a KEY1 event → next cycle `oMode` = 0, fast flag unchanged, no further enables.
6. **Step counter wrap:** force `oStepCount` to 0xFFFFFFFF, then apply a manual step → `oStepCount` = 0.

Source files
------------

// File: rtl/clk_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clk_ctrl_pkg
// Shared definitions for the clock-step controller. It holds the run-mode
// encoding, which is also the value driven on oMode, and the pushbutton index
// assignments.
// -----------------------------------------------------------------------------
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL    = 2'd0,
        MODE_AUTO_SLOW = 2'd1,
        MODE_AUTO_FAST = 2'd2,
        MODE_BURST     = 2'd3
    } mode_e;

    localparam int NUM_KEYS  = 4;
    localparam int KEY_STEP  = 3;
    localparam int KEY_AUTO  = 2;
    localparam int KEY_FAST  = 1;
    localparam int KEY_BURST = 0;

endpackage

// File: rtl/clk_step_ctrl_if.sv
// -----------------------------------------------------------------------------
// clk_step_ctrl_if
// Groups the board-side and core-side signals of the clock-step controller.
//   iKEY[3:0]      raw active-low pushbuttons
//   iDiv           clock divisor (0 behaves as 1)
//   iBurstLen      enables per burst (0 = burst ignored)
//   iHalt          synchronous halt request from the core
//   oCPU_EN        single-cycle core clock-enable
//   oMode          current run mode (clk_ctrl_pkg::mode_e encoding)
//   oBusy          burst in progress
//   oStepCount     enables issued since reset (wraps)
// Modports: master = stimulus/board side, slave = controller.
// -----------------------------------------------------------------------------
interface clk_step_ctrl_if #(
    parameter int DIV_W   = 8,
    parameter int BURST_W = 16
);
    logic [3:0]         iKEY;
    logic [DIV_W-1:0]   iDiv;
    logic [BURST_W-1:0] iBurstLen;
    logic               iHalt;
    logic               oCPU_EN;
    logic [1:0]         oMode;
    logic               oBusy;
    logic [31:0]        oStepCount;

    modport master (
        output iKEY, iDiv, iBurstLen, iHalt,
        input  oCPU_EN, oMode, oBusy, oStepCount
    );

    modport slave (
        input  iKEY, iDiv, iBurstLen, iHalt,
        output oCPU_EN, oMode, oBusy, oStepCount
    );
endinterface

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Debounces one raw active-low pushbutton. It uses a 2-flop synchroniser and
// then a stability counter. The accepted level changes only after
// DEBOUNCE_CYCLES consecutive synchronised samples that differ from it.
// A press is reported one cycle after the accepted level falls.
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   key_n_i  raw key, 0 = pressed
//   level_o  debounced level (1 = released after reset)
//   press_o  one-cycle pulse per accepted 1->0 transition
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter runs only while the sampled key disagrees with the accepted
    // level. Any sample that agrees restarts the count, so a bounce never
    // accumulates.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= key_n_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            cnt_q        <= cnt_d;
            level_prev_q <= level_q;
            press_q      <= level_prev_q & ~level_q;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;
endmodule

// File: rtl/clk_step_ctrl.sv
// -----------------------------------------------------------------------------
// clk_step_ctrl
// Clock-mode controller for the processor core. It debounces the four board
// keys and sequences the MANUAL, AUTO_SLOW, AUTO_FAST and (optional) BURST run
// modes. It issues a single-cycle core clock-enable in the iCLK_50 domain.
//   iCLK_50   system clock (only clock)
//   iRST_n    asynchronous active-low reset
//   bus       clk_step_ctrl_if.slave: iKEY, iDiv, iBurstLen, iHalt in;
//             oCPU_EN, oMode, oBusy, oStepCount out (all registered)
// Build option: define CLKCTRL_BURST_EN to include BURST mode (KEY0,
// iBurstLen, oBusy). Without it KEY0 and iBurstLen are ignored and oBusy is 0.
// -----------------------------------------------------------------------------
module clk_step_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DIV_W           = 8,
    parameter int SLOW_SHIFT      = 18,
    parameter int BURST_W         = 16
) (
    input  logic           iCLK_50,
    input  logic           iRST_n,
    clk_step_ctrl_if.slave bus
);
    localparam int CW = DIV_W + SLOW_SHIFT;

    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] unused_level;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i   (iCLK_50),
            .rst_ni  (iRST_n),
            .key_n_i (bus.iKEY[k]),
            .level_o (unused_level[k]),
            .press_o (key_press[k])
        );
    end

    mode_e            mode_q, mode_d;
    logic             fast_q, fast_d;
    logic             en_q, en_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [31:0]      step_cnt_q, step_cnt_d;
    logic [DIV_W-1:0] div_eff;
    logic [CW-1:0]    period;
    logic             tick;

`ifdef CLKCTRL_BURST_EN
    logic               busy_q, busy_d;
    logic [BURST_W-1:0] rem_q, rem_d;
`else
    logic unused_burst;
    assign unused_burst = ^{bus.iBurstLen, key_press[KEY_BURST]};
`endif

    assign div_eff = (bus.iDiv == '0) ? DIV_W'(1) : bus.iDiv;
    assign period  = (mode_q == MODE_AUTO_SLOW) ? (CW'(div_eff) << SLOW_SHIFT)
                                                : CW'(div_eff);
    // >= rather than == so that lowering iDiv mid-count wraps at once
    // instead of running the counter past the new period.
    assign tick    = (cnt_q >= (period - CW'(1)));

    always_comb begin
        mode_d = mode_q;
        fast_d = fast_q;
        en_d   = 1'b0;
        cnt_d  = '0;
`ifdef CLKCTRL_BURST_EN
        busy_d = busy_q;
        rem_d  = rem_q;
`endif
        if (mode_q != MODE_MANUAL) begin
            if (tick) begin
                en_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (bus.iHalt) begin
            mode_d = MODE_MANUAL;
            en_d   = 1'b0;
`ifdef CLKCTRL_BURST_EN
            busy_d = 1'b0;
`endif
        end else begin
            case (mode_q)
                MODE_MANUAL: begin
                    // Key priority: AUTO > BURST > FAST > STEP.
                    if (key_press[KEY_AUTO]) begin
                        mode_d = fast_q ? MODE_AUTO_FAST : MODE_AUTO_SLOW;
`ifdef CLKCTRL_BURST_EN
                    end else if (key_press[KEY_BURST] && (bus.iBurstLen != '0)) begin
                        mode_d = MODE_BURST;
                        rem_d  = bus.iBurstLen;
                        busy_d = 1'b1;
`endif
                    end else if (key_press[KEY_FAST]) begin
                        fast_d = ~fast_q;
                    end else if (key_press[KEY_STEP]) begin
                        en_d = 1'b1;
                    end
                end
                MODE_AUTO_SLOW, MODE_AUTO_FAST: begin
                    if (key_press[KEY_AUTO]) begin
                        mode_d = MODE_MANUAL;
                        en_d   = 1'b0;
                    end else if (key_press[KEY_FAST]) begin
                        fast_d = ~fast_q;
                        mode_d = fast_q ? MODE_AUTO_SLOW : MODE_AUTO_FAST;
                        en_d   = 1'b0;
                    end
                end
`ifdef CLKCTRL_BURST_EN
                MODE_BURST: begin
                    if (key_press[KEY_AUTO]) begin
                        mode_d = MODE_MANUAL;
                        en_d   = 1'b0;
                        busy_d = 1'b0;
                    end else if (tick) begin
                        rem_d = rem_q - 1'b1;
                        // The final enable and the return to MANUAL are
                        // registered on the same edge.
                        if (rem_q == BURST_W'(1)) begin
                            mode_d = MODE_MANUAL;
                            busy_d = 1'b0;
                        end
                    end
                end
`endif
                default: mode_d = MODE_MANUAL;
            endcase
        end

        // Every mode change restarts the period from zero.
        if (mode_d != mode_q) begin
            cnt_d = '0;
        end
    end

    assign step_cnt_d = step_cnt_q + 32'(en_d);

    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            mode_q     <= MODE_MANUAL;
            fast_q     <= 1'b0;
            en_q       <= 1'b0;
            cnt_q      <= '0;
            step_cnt_q <= '0;
`ifdef CLKCTRL_BURST_EN
            busy_q     <= 1'b0;
            rem_q      <= '0;
`endif
        end else begin
            mode_q     <= mode_d;
            fast_q     <= fast_d;
            en_q       <= en_d;
            cnt_q      <= cnt_d;
            step_cnt_q <= step_cnt_d;
`ifdef CLKCTRL_BURST_EN
            busy_q     <= busy_d;
            rem_q      <= rem_d;
`endif
        end
    end

    assign bus.oCPU_EN    = en_q;
    assign bus.oMode      = mode_q;
    assign bus.oStepCount = step_cnt_q;
`ifdef CLKCTRL_BURST_EN
    assign bus.oBusy      = busy_q;
`else
    assign bus.oBusy      = 1'b0;
`endif
endmodule

// File: tb/tb_clk_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_step_ctrl
// Directed and randomised checks of clk_step_ctrl with DEBOUNCE_CYCLES = 4 and
// SLOW_SHIFT = 2. A negedge monitor logs every enable pulse and every mode
// change. The expected mode, fast flag, step counts and enable timing come
// from a small rule model of the key handling and from the period arithmetic
// max(div,1) << shift.
// -----------------------------------------------------------------------------
module tb_clk_step_ctrl;
    localparam int DEB   = 4;
    localparam int SHIFT = 2;

    logic clk;
    logic rst_n;

    clk_step_ctrl_if #(.DIV_W(8), .BURST_W(16)) ifc ();

    clk_step_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .DIV_W           (8),
        .SLOW_SHIFT      (SHIFT),
        .BURST_W         (16)
    ) dut (
        .iCLK_50 (clk),
        .iRST_n  (rst_n),
        .bus     (ifc.slave)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- monitor ----------------
    int         n_chk;
    int         n_fail;
    int         cyc;
    int         en_total;
    int         en_cyc[$];
    int         mode_chg_cyc;
    int         burst_entry_cyc;
    int         busy_fall_cyc;
    logic [1:0] last_mode;
    logic       last_busy;

    always @(negedge clk) begin
        cyc++;
        if (ifc.oCPU_EN === 1'b1) begin
            en_total++;
            en_cyc.push_back(cyc);
        end
        if (ifc.oMode !== last_mode) begin
            mode_chg_cyc = cyc;
            if (ifc.oMode === 2'd3) burst_entry_cyc = cyc;
        end
        if (last_busy === 1'b1 && ifc.oBusy === 1'b0) busy_fall_cyc = cyc;
        last_mode = ifc.oMode;
        last_busy = ifc.oBusy;
    end

    // ---------------- reference model ----------------
    int m_mode;
    int m_fast;

    task automatic model_key(input int k);
        if (m_mode == 0) begin
            if (k == 2)      m_mode = (m_fast != 0) ? 2 : 1;
            else if (k == 1) m_fast = 1 - m_fast;
        end else if (m_mode == 1 || m_mode == 2) begin
            if (k == 2) m_mode = 0;
            else if (k == 1) begin
                m_fast = 1 - m_fast;
                m_mode = (m_fast != 0) ? 2 : 1;
            end
        end
    endtask

    function automatic int exp_period(input int div, input int slow);
        int d;
        d = (div == 0) ? 1 : div;
        return (slow != 0) ? (d << SHIFT) : d;
    endfunction

    // ---------------- driver / check helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_key(input int k);
        ifc.iKEY[k] = 1'b0;
        repeat (10) tick();
        ifc.iKEY[k] = 1'b1;
        repeat (10) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic window_stats(input int start, input int stop, input int p,
                                output int n, output int first_off,
                                output int bad, output int last);
        int prev;
        n = 0; first_off = -1; bad = 0; last = -1; prev = -1;
        foreach (en_cyc[i]) begin
            if (en_cyc[i] > start && en_cyc[i] <= stop) begin
                if (n == 0) first_off = en_cyc[i] - start;
                else if (en_cyc[i] - prev != p) bad++;
                prev = en_cyc[i];
                last = en_cyc[i];
                n++;
            end
        end
    endtask

    // Enables since the last mode entry: the first comes p cycles after entry,
    // then one every p cycles.
    task automatic check_auto(input string tag, input int p);
        int n, first_off, bad, last, start;
        start = mode_chg_cyc;
        window_stats(start, cyc, p, n, first_off, bad, last);
        chk({tag, "_mode"}, 32'(ifc.oMode), 32'(m_mode));
        chk({tag, "_count"}, 32'(n), 32'((cyc - start) / p));
        chk({tag, "_first"}, 32'(first_off), 32'(p));
        chk({tag, "_spacing"}, 32'(bad), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    int base, p, div, h, nman;

    initial begin
        ifc.iKEY      = 4'hF;
        ifc.iDiv      = 8'd1;
        ifc.iBurstLen = 16'd0;
        ifc.iHalt     = 1'b0;
        m_mode        = 0;
        m_fast        = 0;

        // 1. reset
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("reset_mode", 32'(ifc.oMode), 32'd0);
        chk("reset_en", 32'(ifc.oCPU_EN), 32'd0);
        chk("reset_steps", ifc.oStepCount, 32'd0);
        chk("reset_busy", 32'(ifc.oBusy), 32'd0);
        base = en_total;

        // 2. bounce rejection, then a real press
        ifc.iKEY[3] = 1'b0;
        repeat (2) tick();
        ifc.iKEY[3] = 1'b1;
        repeat (10) tick();
        chk("bounce_no_pulse", 32'(en_total - base), 32'd0);
        press_key(3);
        chk("manual_one_pulse", 32'(en_total - base), 32'd1);
        chk("manual_stepcount", ifc.oStepCount, 32'd1);

        // random number of manual steps
        nman = $urandom_range(1, 4);
        for (int i = 0; i < nman; i++) press_key(3);
        chk("manual_rand_steps", ifc.oStepCount, 32'(1 + nman));

        // press-to-event and event-to-enable latency, single-cycle width
        ifc.iKEY[3] = 1'b0;
        repeat (DEB + 3) tick();
        chk("lat_before", 32'(ifc.oCPU_EN), 32'd0);
        tick();
        chk("lat_pulse", 32'(ifc.oCPU_EN), 32'd1);
        tick();
        chk("lat_width", 32'(ifc.oCPU_EN), 32'd0);
        ifc.iKEY[3] = 1'b1;
        repeat (10) tick();
        chk("manual_total", ifc.oStepCount, 32'(2 + nman));

        // 3. auto modes
        ifc.iDiv = 8'd3;
        press_key(2); model_key(2);
        repeat (60) tick();
        check_auto("auto_slow", exp_period(3, 1));
        press_key(1); model_key(1);
        repeat (12) tick();
        check_auto("auto_fast", exp_period(3, 0));
        ifc.iDiv = 8'd0;
        repeat (3) tick();
        h = cyc;
        repeat (10) tick();
        begin
            int n, f, b, l;
            window_stats(h, cyc, 1, n, f, b, l);
            chk("div0_count", 32'(n), 32'(cyc - h));
            chk("div0_spacing", 32'(b), 32'd0);
        end

        // random divisors, re-entering AUTO through MANUAL
        for (int i = 0; i < 3; i++) begin
            press_key(2); model_key(2);
            chk("rand_to_manual", 32'(ifc.oMode), 32'(m_mode));
            div = $urandom_range(0, 7);
            ifc.iDiv = 8'(div);
            press_key(2); model_key(2);
            p = exp_period(div, (m_mode == 1) ? 1 : 0);
            repeat (4 * p) tick();
            check_auto("rand_auto", p);
        end
        press_key(1); model_key(1);
        p = exp_period(div, (m_mode == 1) ? 1 : 0);
        repeat (4 * p) tick();
        check_auto("rand_slow", p);
        press_key(1); model_key(1);

        // 5. halt together with a KEY1 event in AUTO_FAST
        ifc.iDiv = 8'd3;
        repeat (10) tick();
        chk("halt_pre_mode", 32'(ifc.oMode), 32'd2);
        ifc.iKEY[1] = 1'b0;
        repeat (DEB + 3) tick();
        ifc.iHalt = 1'b1;
        tick();
        ifc.iHalt = 1'b0;
        ifc.iKEY[1] = 1'b1;
        m_mode = 0;
        chk("halt_mode", 32'(ifc.oMode), 32'd0);
        chk("halt_no_en", 32'(ifc.oCPU_EN), 32'd0);
        h = en_total;
        repeat (20) tick();
        chk("halt_quiet", 32'(en_total - h), 32'd0);
        press_key(2); model_key(2);
        chk("halt_fast_kept", 32'(ifc.oMode), 32'(m_mode));
        press_key(2); model_key(2);
        chk("back_manual", 32'(ifc.oMode), 32'd0);

        // 4. burst
`ifdef CLKCTRL_BURST_EN
        for (int i = 0; i < 4; i++) begin
            int len, n, f, b, l;
            if (i == 0) begin
                len = 5; div = 2;
            end else begin
                len = $urandom_range(1, 6); div = $urandom_range(0, 3);
            end
            ifc.iBurstLen = 16'(len);
            ifc.iDiv      = 8'(div);
            p = exp_period(div, 0);
            press_key(0);
            repeat (len * p + 5) tick();
            window_stats(burst_entry_cyc, cyc, p, n, f, b, l);
            chk("burst_count", 32'(n), 32'(len));
            chk("burst_first", 32'(f), 32'(p));
            chk("burst_spacing", 32'(b), 32'd0);
            chk("burst_busy_fall", 32'(busy_fall_cyc), 32'(l));
            chk("burst_end_mode", 32'(ifc.oMode), 32'd0);
            chk("burst_end_busy", 32'(ifc.oBusy), 32'd0);
        end
        ifc.iBurstLen = 16'd0;
        h = en_total;
        press_key(0);
        chk("burst_len0_mode", 32'(ifc.oMode), 32'd0);
        chk("burst_len0_en", 32'(en_total - h), 32'd0);
        ifc.iBurstLen = 16'd1000;
        ifc.iDiv = 8'd3;
        press_key(0);
        chk("burst_long_busy", 32'(ifc.oBusy), 32'd1);
        chk("burst_long_mode", 32'(ifc.oMode), 32'd3);
        press_key(2);
        chk("burst_abort_mode", 32'(ifc.oMode), 32'd0);
        chk("burst_abort_busy", 32'(ifc.oBusy), 32'd0);
`else
        ifc.iBurstLen = 16'd5;
        h = en_total;
        press_key(0);
        chk("noburst_mode", 32'(ifc.oMode), 32'd0);
        chk("noburst_busy", 32'(ifc.oBusy), 32'd0);
        chk("noburst_en", 32'(en_total - h), 32'd0);
`endif
        chk("stepcount_total", ifc.oStepCount, 32'(en_total - base));

        // 6. step counter wrap
        force dut.step_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.step_cnt_q;
        tick();
        chk("wrap_preset", ifc.oStepCount, 32'hFFFF_FFFF);
        press_key(3);
        chk("wrap_zero", ifc.oStepCount, 32'd0);

        // asynchronous reset in the middle of AUTO operation
        ifc.iDiv = 8'd1;
        press_key(2); model_key(2);
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mode", 32'(ifc.oMode), 32'd0);
        chk("async_rst_en", 32'(ifc.oCPU_EN), 32'd0);
        chk("async_rst_steps", ifc.oStepCount, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_mode = 0;
        m_fast = 0;
        repeat (5) tick();
        chk("post_rst_mode", 32'(ifc.oMode), 32'd0);
        press_key(2); model_key(2);
        chk("post_rst_slow", 32'(ifc.oMode), 32'(m_mode));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
